// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, d = x - y - bin, one bit per cycle LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             rst_q;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_next;
  logic             borrow;
  logic             borrow_next;
  logic [CW-1:0]    cnt;
  logic             xi;
  logic             yi;
  logic             di;
  logic             last_bit;
  logic             accept;

  assign xi          = x_sr[0];
  assign yi          = y_sr[0];
  assign di          = xi ^ yi ^ borrow;
  assign borrow_next = (~xi & yi) | (~xi & borrow) | (yi & borrow);
  assign last_bit    = (cnt == CW'(WIDTH - 1));
  assign d_next      = (d_sr >> 1) | (WIDTH'(di) << (WIDTH - 1));
  assign d           = d_sr;

  // rst_q keeps in_ready low while reset is asserted, even once the state is already IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rst_q <= 1'b1;
    end else begin
      state <= state_next;
      rst_q <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst_q;
        if (in_valid && !rst_q) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter from the MSB side so d is already aligned once the last bit lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sr   <= '0;
      y_sr   <= '0;
      d_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      x_sr   <= x;
      y_sr   <= y;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      x_sr   <= x_sr >> 1;
      y_sr   <= y_sr >> 1;
      d_sr   <= d_next;
      borrow <= borrow_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        bout <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (xi != yi) && (di != xi);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, reset/backpressure, random ops, WIDTH=1 sweep.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] x, y, d;
  logic       bin, bout;
  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [0:0] x1, y1, d1;
  logic       bin1, bout1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf1;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .x(x1), .y(y1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .d(d1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 8-bit instance, checked against plain integer arithmetic.
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv, input logic bv);
    int         cyc;
    int         diff;
    logic [7:0] ed;
    logic       eb;
    diff = int'(xv) - int'(yv) - int'(bv);
    ed   = diff[7:0];
    eb   = (int'(xv) < int'(yv) + int'(bv));
    cyc  = 0;
    while (!in_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    x = xv; y = yv; bin = bv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("latency8", 32'(cyc), 32'd8);
    checkOutput("d8", 32'(d), 32'(ed));
    checkOutput("bout8", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("ovf8", 32'(ovf), 32'((xv[7] != yv[7]) && (ed[7] != xv[7])));
`endif
    if (out_ready) begin
      tick();
      checkOutput("valid_pulse", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    int         cyc;
    int         spurious;
    int         diff;
    logic [7:0] held_d;
    logic       xb, yb, bb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; bin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; x1 = '0; y1 = '0; bin1 = 1'b0;
    repeat (3) tick();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_d", 32'(d), 32'd0);
    checkOutput("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed cases");
    applyStimulus(8'h35, 8'h12, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0);
    applyStimulus(8'h10, 8'h0F, 1'b1);
    applyStimulus(8'h80, 8'h01, 1'b0);
    applyStimulus(8'h05, 8'h03, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h9C, 8'h47, 1'b1);
    held_d = d;
    checkOutput("bp_d_value", 32'(held_d), 32'h54);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x = 8'h01; y = 8'h02; bin = 1'b0;
      tick();
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_d", 32'(d), 32'h54);
      checkOutput("bp_bout", 32'(bout), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);

    $display("[TB] reset during RUN");
    x = 8'hAA; y = 8'h11; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_d", 32'(d), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("mid_rst_idle", 32'(in_ready), 32'd1);
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) spurious++;
      tick();
    end
    checkOutput("no_spurious_result", 32'(spurious), 32'd0);
    applyStimulus(8'h7F, 8'h7F, 1'b0);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] WIDTH=1 sweep");
    for (int i = 0; i < 8; i++) begin
      xb = i[2]; yb = i[1]; bb = i[0];
      cyc = 0;
      while (!in_ready1 && cyc < 10) begin
        tick();
        cyc++;
      end
      checkOutput("w1_in_ready", 32'(in_ready1), 32'd1);
      x1 = xb; y1 = yb; bin1 = bb; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      cyc = 0;
      while (!out_valid1 && cyc < 10) begin
        tick();
        cyc++;
      end
      diff = int'(xb) - int'(yb) - int'(bb);
      checkOutput("w1_latency", 32'(cyc), 32'd1);
      checkOutput("w1_d", 32'(d1), 32'(diff[0]));
      checkOutput("w1_bout", 32'(bout1), 32'(int'(xb) < int'(yb) + int'(bb)));
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("w1_ovf", 32'(ovf1), 32'((xb != yb) && (diff[0] != xb)));
`endif
      tick();
      checkOutput("w1_pulse", 32'(out_valid1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `d = x - y - bin` over `WIDTH` clock cycles, one bit per cycle, LSB first. It uses the full-subtractor (borrow) recurrence. It is the area-minimal counterpart to the combinational adders in the integer add/sub library. Both sides use valid/ready handshakes so it can sit between pipeline stages.

## Interface

- `WIDTH`, default 8: operand/result width in bits; legal range `WIDTH >= 1`.

- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset: synchronous, active-high. Returns the FSM to IDLE and clears all outputs.
- `in_valid`  input  1  operands `x`, `y`, `bin` are valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `x`  input  WIDTH  minuend.
- `y`  input  WIDTH  subtrahend.
- `bin`  input  1  borrow-in.
- `out_valid`  output  1  result valid; high only in DONE.
- `out_ready`  input  1  consumer accepts the result.
- `d`  output  WIDTH  difference, `x - y - bin` mod 2^WIDTH.
- `bout`  output  1  borrow-out; 1 iff `x < y + bin` (unsigned).
- `ovf`  output  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation

- FSM states:
  - IDLE: `in_ready=1`. Accept on `in_valid && in_ready`:
    - latch `x` and `y` into shift registers;
    - set the borrow register to `bin`;
    - clear the bit counter;
    - go to RUN.
  - RUN: each cycle, take `xi`, `yi` (the shift-register LSBs) and `b` (borrow register), then:
    - `di = xi ^ yi ^ b`;
    - `b' = (~xi & yi) | (~xi & b) | (yi & b)`;
    - shift `di` into the result register from the MSB side and shift the operand registers right by one;
    - increment the counter.
    - After the `WIDTH`-th bit, go to DONE.
  - DONE: `out_valid=1`. `d` and `bout` (final `b'`) stay stable until `out_ready`; on `out_valid && out_ready`, go to IDLE.
- Inputs are ignored outside IDLE. `x`/`y` may change freely after acceptance.
- The counter is `$clog2(WIDTH+1)` bits wide and never wraps within an operation.
- `WIDTH=1`: RUN lasts exactly one cycle.
- Outputs `d`, `bout`, `ovf` are registered. Their values outside DONE are don't-care to consumers, but they must not glitch in DONE.
- `rst` high in any state, including mid-RUN or DONE:
  - next state is IDLE;
  - the in-flight operation is discarded and no `out_valid` is produced for it.
- Reset values:
  - `in_ready=0` while `rst` is high, 1 on the first cycle after release;
  - `out_valid=0`, `d=0`, `bout=0`, `ovf=0`.

## Timing

- Acceptance edge is E0.
- RUN spans edges E1..E(WIDTH). `out_valid` rises after edge E(WIDTH).
- Latency: `WIDTH` cycles from acceptance to `out_valid`.
- With `out_ready` held high, `out_valid` lasts 1 cycle. IDLE follows, and `in_ready` is high one cycle later.
- Back-to-back throughput: one result per `WIDTH+2` cycles.
- There is no combinational path from inputs to outputs. `in_ready` and `out_valid` are decoded from the state register only.

## Configuration

- `SERIAL_SUB_OVF_EN` defined:
  - port `ovf` exists;
  - `ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB])`, evaluated during the final RUN cycle from `xi`, `yi`, `di`;
  - `ovf` is registered with `d` and valid in DONE.
- Undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan

- WIDTH=8, `x=0x35`, `y=0x12`, `bin=0`, `out_ready=1` -> `d=0x23`, `bout=0`; `out_valid` exactly 8 cycles after the acceptance edge, high for 1 cycle.
- `x=0x00`, `y=0x01`, `bin=0` -> `d=0xFF`, `bout=1`. Then `x=0x10`, `y=0x0F`, `bin=1` -> `d=0x00`, `bout=0`.
- Backpressure: `out_ready=0` for 5 cycles after `out_valid` rises -> `d`, `bout`, `out_valid` constant, `in_ready=0`, and a new `in_valid` is ignored. Then `out_ready=1` -> IDLE the next cycle.
- Reset mid-RUN (3rd bit cycle) -> next cycle: state IDLE, `out_valid=0`, `d=0`; no spurious result afterwards; a following op `0x7F-0x7F` gives `d=0x00`, `bout=0`.
- `SERIAL_SUB_OVF_EN`, `x=0x80`, `y=0x01` -> `d=0x7F`, `bout=0`, `ovf=1`. `x=0x05`, `y=0x03` -> `ovf=0`.
- WIDTH=1 sweep of all 8 `(x,y,bin)` combinations -> `d`/`bout` match the truth table; latency 1 cycle.
